// File: rtl/wishbone_ctrl_pkg.sv
// wishbone_ctrl_pkg: status/state types and width helpers shared by the burst controller
package wishbone_ctrl_pkg;
  typedef enum logic [1:0] {WB_OK = 2'd0, WB_ERR = 2'd1, WB_TIMEOUT = 2'd2} wb_status_t;
  typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} ctrl_state_t;
  function automatic int len_w(input int max_burst);
    return max_burst > 1 ? $clog2(max_burst) : 1;
  endfunction
  function automatic int wd_w(input int timeout);
    return timeout > 0 ? $clog2(timeout + 1) : 1;
  endfunction
endpackage

// File: rtl/wishbone_ctrl_burst_watchdog.sv
// wb_beat_watchdog: acked-beat counter with last-beat flag and per-beat no-response watchdog
module wb_beat_watchdog import wishbone_ctrl_pkg::*; #(
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT = 255,
  localparam int LEN_W = len_w(MAX_BURST),
  localparam int BEATS_W = $clog2(MAX_BURST) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load,
  input  logic [LEN_W-1:0]   len,
  input  logic               ack,
  input  logic               tick,
  output logic [BEATS_W-1:0] beat_cnt,
  output logic               last,
  output logic               expired
);
  localparam int WD_W = wd_w(TIMEOUT);
  localparam int TO_M1 = TIMEOUT > 0 ? TIMEOUT - 1 : 0;
  logic [LEN_W-1:0] len_q, len_d;
  logic [BEATS_W-1:0] beat_q, beat_d;
  logic [WD_W-1:0] wd_q, wd_d;
  always_comb begin
    len_d = load ? len : len_q;
    beat_d = load ? '0 : ack ? beat_q + BEATS_W'(1) : beat_q;
    wd_d = (load || ack) ? '0 : tick ? wd_q + WD_W'(1) : wd_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q <= '0;
      beat_q <= '0;
      wd_q <= '0;
    end else begin
      len_q <= len_d;
      beat_q <= beat_d;
      wd_q <= wd_d;
    end
  end
  // expiry fires in the TIMEOUT-th silent cycle so the transition ends the bus phase on time
  assign expired = (TIMEOUT != 0) && (wd_q == WD_W'(TO_M1));
  assign last = beat_q == BEATS_W'(len_q);
  assign beat_cnt = beat_q;
endmodule

// File: rtl/wishbone_ctrl_burst.sv
// wishbone_ctrl_burst: Wishbone B4 classic master running 1..MAX_BURST beat incrementing bursts
module wishbone_ctrl_burst import wishbone_ctrl_pkg::*; #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 32,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT = 255,
  localparam int SEL_WIDTH = DAT_WIDTH / 8,
  localparam int LEN_W = len_w(MAX_BURST),
  localparam int BEATS_W = $clog2(MAX_BURST) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADR_WIDTH-1:0] req_adr,
  input  logic                 req_we,
  input  logic [SEL_WIDTH-1:0] req_sel,
  input  logic [LEN_W-1:0]     req_len,
  input  logic [DAT_WIDTH-1:0] wr_data,
  output logic                 wr_take,
  output logic [DAT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output wb_status_t           status,
  output logic [BEATS_W-1:0]   beats,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [ADR_WIDTH-1:0] adr_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  input  logic [DAT_WIDTH-1:0] dat_i,
  input  logic                 ack_i,
  input  logic                 err_i
);
  ctrl_state_t state_q, state_d;
  logic bus, accept, beat_ok, fin_ok, fin_err, fin_to, fin, stay, last, expired;
  logic [BEATS_W-1:0] beat_cnt;
  logic cyc_q, cyc_d, we_q, we_d, rd_valid_q, rd_valid_d, done_q, done_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d, rd_data_q, rd_data_d;
  wb_status_t status_q, status_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  assign bus = state_q == S_BUS;
  assign req_ready = !rst_i && !bus;
  assign accept = req_valid && req_ready;
  // err wins over a simultaneous ack
  assign beat_ok = bus && ack_i && !err_i;
  assign fin_ok = beat_ok && last;
  assign fin_err = bus && err_i;
  assign fin_to = bus && !ack_i && !err_i && expired;
  assign fin = fin_ok || fin_err || fin_to;
  assign wr_take = (accept && req_we) || (beat_ok && we_q && !last);
  wb_beat_watchdog #(.MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) u_wd (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .load(accept),
    .len(req_len),
    .ack(beat_ok),
    .tick(bus && !ack_i && !err_i),
    .beat_cnt(beat_cnt),
    .last(last),
    .expired(expired)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = bus ? (fin ? S_IDLE : S_BUS) : (accept ? S_BUS : S_IDLE);
  end
  always_comb begin
    stay = state_d == S_BUS;
    cyc_d = stay;
    we_d = accept ? req_we : stay && we_q;
    sel_d = accept ? req_sel : stay ? sel_q : '0;
    adr_d = accept ? req_adr : !stay ? '0 : beat_ok ? adr_q + ADR_WIDTH'(1) : adr_q;
    dat_d = accept ? (req_we ? wr_data : '0) : !stay ? '0 : (beat_ok && we_q) ? wr_data : dat_q;
    rd_valid_d = beat_ok && !we_q;
    rd_data_d = rd_valid_d ? dat_i : rd_data_q;
    done_d = fin;
    status_d = fin_err ? WB_ERR : fin_to ? WB_TIMEOUT : WB_OK;
    beats_d = fin_ok ? beat_cnt + BEATS_W'(1) : fin ? beat_cnt : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q <= 1'b0;
      we_q <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      done_q <= 1'b0;
      status_q <= WB_OK;
      beats_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      we_q <= we_d;
      sel_q <= sel_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      done_q <= done_d;
      status_q <= status_d;
      beats_q <= beats_d;
    end
  end
  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign we_o = we_q;
  assign sel_o = sel_q;
  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign done = done_q;
  assign status = status_q;
  assign beats = beats_q;
endmodule

// File: tb/tb_wishbone_ctrl_burst.sv
// tb_wishbone_ctrl_burst: directed bursts against a scripted target, checked by a transaction-level model
module tb_wishbone_ctrl_burst;
  import wishbone_ctrl_pkg::*;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [15:0] req_adr = '0;
  logic [3:0] req_sel = '0, req_len = '0;
  logic [31:0] wr_data = '0, dat_i = '0;
  logic ack_i = 1'b0, err_i = 1'b0;
  logic req_ready, wr_take, rd_valid, done, cyc_o, stb_o, we_o;
  logic [31:0] rd_data, dat_o;
  wb_status_t status;
  logic [4:0] beats;
  logic [15:0] adr_o;
  logic [3:0] sel_o;
  int total = 0, bad = 0;

  wishbone_ctrl_burst #(.TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid(req_valid), .req_ready(req_ready),
    .req_adr(req_adr), .req_we(req_we), .req_sel(req_sel), .req_len(req_len),
    .wr_data(wr_data), .wr_take(wr_take), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .status(status), .beats(beats), .cyc_o(cyc_o), .stb_o(stb_o),
    .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i),
    .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdpat(input logic [15:0] a);
    return a == 16'h0010 ? 32'hDEADBEEF : {~a, a};
  endfunction
  function automatic logic [31:0] wrpat(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00010101;
  endfunction

  // scripted target: t_ws wait states per beat, err on beat t_eb, or never answers
  int t_ws = 0, t_eb = -1, t_w = 0, t_beat = 0;
  bit t_sil = 1'b0;
  always @(negedge clk) begin
    ack_i = 1'b0;
    err_i = 1'b0;
    if (cyc_o && !t_sil && t_w == t_ws) begin
      ack_i = 1'b1;
      err_i = t_beat == t_eb;
      dat_i = rdpat(adr_o);
    end
  end
  always @(posedge clk) begin
    if (!cyc_o) begin
      t_w = 0;
      t_beat = 0;
    end else if (ack_i || err_i) begin
      t_w = 0;
      t_beat++;
    end else t_w++;
  end

  // write-data source, popped whenever the model says a word is consumed
  int wi = 0;
  always @(negedge clk) wr_data = wrpat(wi);

  // transaction-level model: what the bus must look like during the next cycle
  bit started = 1'b0, m_act = 1'b0, m_we = 1'b0, e_done = 1'b0, e_rdv = 1'b0, tk;
  logic [15:0] m_adr = '0;
  logic [3:0] m_sel = '0;
  logic [31:0] m_dat = '0, m_rdd = '0;
  logic [1:0] e_status = '0;
  int m_len = 0, m_acked = 0, m_wait = 0, e_beats = 0;

  function automatic logic exp_take();
    return (!m_act && req_valid && req_we) || (m_act && m_we && ack_i && !err_i && m_acked != m_len);
  endfunction

  task automatic m_end(input logic [1:0] st, input int nb);
    m_act = 1'b0; m_we = 1'b0; m_adr = '0; m_sel = '0; m_dat = '0;
    e_done = 1'b1; e_status = st; e_beats = nb;
  endtask

  always @(posedge clk) begin
    tk = exp_take();
    e_done = 1'b0; e_rdv = 1'b0; e_status = '0; e_beats = 0;
    if (rst_i) begin
      started = 1'b1;
      m_act = 1'b0; m_we = 1'b0; m_adr = '0; m_sel = '0; m_dat = '0; m_rdd = '0;
    end else begin
      if (tk) wi++;
      if (!m_act) begin
        if (req_valid) begin
          m_act = 1'b1; m_adr = req_adr; m_we = req_we; m_sel = req_sel; m_len = int'(req_len);
          m_acked = 0; m_wait = 0; m_dat = req_we ? wr_data : '0;
        end
      end else if (err_i) m_end(2'd1, m_acked);
      else if (ack_i) begin
        if (!m_we) begin
          e_rdv = 1'b1;
          m_rdd = rdpat(m_adr);
        end
        if (m_acked == m_len) m_end(2'd0, m_len + 1);
        else begin
          m_acked++; m_adr = m_adr + 16'd1; m_wait = 0;
          if (m_we) m_dat = wr_data;
        end
      end else begin
        m_wait++;
        if (m_wait == TMO) m_end(2'd2, m_acked);
      end
    end
  end

  always @(negedge clk) begin
    #4;
    if (started) begin
      chk("cyc_o", 32'(cyc_o), 32'(m_act));
      chk("stb_o", 32'(stb_o), 32'(m_act));
      chk("we_o", 32'(we_o), 32'(m_we));
      chk("adr_o", 32'(adr_o), 32'(m_adr));
      chk("sel_o", 32'(sel_o), 32'(m_sel));
      chk("dat_o", dat_o, m_dat);
      chk("done", 32'(done), 32'(e_done));
      chk("status", 32'(status), 32'(e_status));
      chk("beats", 32'(beats), 32'(e_beats));
      chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
      chk("rd_data", rd_data, m_rdd);
      if (!rst_i) begin
        chk("req_ready", 32'(req_ready), 32'(!m_act));
        chk("wr_take", 32'(wr_take), 32'(exp_take()));
      end
    end
  end

  int r_nc, r_nrd, r_bt, r_st;
  logic [31:0] r_lrd;
  logic r_cyc_done;
  logic [15:0] r_adrs[0:31];

  task automatic run(input logic [15:0] a, input logic w, input logic [3:0] s, input logic [3:0] l,
                     input int ws, input int eb, input bit sil);
    bit got = 1'b0;
    r_nc = 0; r_nrd = 0; r_bt = -1; r_st = -1; r_lrd = '0; r_cyc_done = 1'b1;
    @(negedge clk);
    t_ws = ws; t_eb = eb; t_sil = sil;
    req_valid = 1'b1; req_adr = a; req_we = w; req_sel = s; req_len = l;
    @(negedge clk);
    req_valid = 1'b0;
    #2;
    for (int i = 0; i < 300 && !got; i++) begin
      if (cyc_o) begin
        if (r_nc < 32) r_adrs[r_nc] = adr_o;
        r_nc++;
      end
      if (rd_valid) begin
        r_nrd++;
        r_lrd = rd_data;
      end
      if (done) begin
        got = 1'b1; r_st = int'(status); r_bt = int'(beats); r_cyc_done = cyc_o;
      end else begin
        @(negedge clk);
        #2;
      end
    end
    if (!got) chk("burst_bound", 32'd0, 32'd1);
  endtask

  initial begin
    int p0, nd;
    bit got;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    #2;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_cyc", 32'(cyc_o), 32'd0);

    run(16'h0010, 1'b0, 4'hF, 4'd0, 0, -1, 1'b0);
    chk("t1_cyc_len", r_nc, 1);
    chk("t1_rd_cnt", r_nrd, 1);
    chk("t1_rd_data", r_lrd, 32'hDEADBEEF);
    chk("t1_status", r_st, 0);
    chk("t1_beats", r_bt, 1);

    p0 = wi;
    run(16'hFFFE, 1'b1, 4'b0011, 4'd3, 0, -1, 1'b0);
    chk("t2_adr0", 32'(r_adrs[0]), 32'hFFFE);
    chk("t2_adr1", 32'(r_adrs[1]), 32'hFFFF);
    chk("t2_adr2", 32'(r_adrs[2]), 32'h0000);
    chk("t2_adr3", 32'(r_adrs[3]), 32'h0001);
    chk("t2_pops", wi - p0, 4);
    chk("t2_beats", r_bt, 4);
    chk("t2_cyc_len", r_nc, 4);

    run(16'h0040, 1'b0, 4'hC, 4'd7, 2, -1, 1'b0);
    chk("t3_cyc_len", r_nc, 24);
    chk("t3_rd_cnt", r_nrd, 8);
    chk("t3_last_rd", r_lrd, 32'hFFB80047);
    chk("t3_status", r_st, 0);
    chk("t3_beats", r_bt, 8);

    run(16'h0200, 1'b0, 4'hF, 4'd5, 0, 2, 1'b0);
    chk("t4_status", r_st, 1);
    chk("t4_beats", r_bt, 2);
    chk("t4_cyc_len", r_nc, 3);
    chk("t4_cyc_low", 32'(r_cyc_done), 32'd0);

    run(16'h0300, 1'b0, 4'hF, 4'd3, 0, -1, 1'b1);
    chk("t5_cyc_len", r_nc, TMO);
    chk("t5_status", r_st, 2);
    chk("t5_beats", r_bt, 0);

    @(negedge clk);
    t_sil = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_adr = 16'h1234; req_len = 4'd3; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    #2;
    chk("rst_cyc", 32'(cyc_o), 32'd0);
    chk("rst_adr", 32'(adr_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      #2;
      if (done) nd++;
    end
    chk("rst_no_done", nd, 0);
    chk("rst_ready_after", 32'(req_ready), 32'd1);

    @(negedge clk);
    t_ws = 0; t_eb = -1; t_sil = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 16'h0100; req_len = 4'd1; req_sel = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      #2;
      got = done;
    end
    chk("b2b_first_done", 32'(got), 32'd1);
    chk("b2b_gap_low", 32'(cyc_o), 32'd0);
    chk("b2b_first_beats", 32'(beats), 32'd2);
    req_adr = 16'h0200; req_len = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    #2;
    chk("b2b_second_cyc", 32'(cyc_o), 32'd1);
    chk("b2b_second_adr", 32'(adr_o), 32'h0200);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      #2;
      got = done;
    end
    chk("b2b_second_done", 32'(got), 32'd1);
    chk("b2b_second_beats", 32'(beats), 32'd3);
    chk("b2b_second_status", 32'(status), 32'd0);

    @(negedge clk);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
